// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin front end for one port of a byte-column-write block RAM.
// Decodes byte addresses, drives the RAM port and returns 1-cycle-latency responses with an out-of-range flag.
module ram_port_arbiter #(
    parameter int unsigned RAM_DEPTH = 16384,
    parameter int unsigned COL_WIDTH = 8,
    parameter int unsigned COL_NUM   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned W  = COL_NUM * COL_WIDTH,
    localparam int unsigned AW = $clog2(RAM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        m0_addr,
    input  logic [W-1:0]       m0_wdata,
    input  logic [COL_NUM-1:0] m0_wmask,
    input  logic               m0_valid,
    output logic               m0_ready,
    output logic [W-1:0]       m0_rdata,
    output logic               m0_rvalid,
    output logic               m0_error,
    input  logic [31:0]        m1_addr,
    input  logic [W-1:0]       m1_wdata,
    input  logic [COL_NUM-1:0] m1_wmask,
    input  logic               m1_valid,
    output logic               m1_ready,
    output logic [W-1:0]       m1_rdata,
    output logic               m1_rvalid,
    output logic               m1_error,
    output logic [AW-1:0]      ram_addr,
    output logic [W-1:0]       ram_din,
    output logic               ram_en,
    output logic [COL_NUM-1:0] ram_we,
    input  logic [W-1:0]       ram_dout
);

    localparam int unsigned CB   = $clog2(COL_NUM);
    localparam logic [32:0]  SPAN = 33'(RAM_DEPTH) * 33'(COL_NUM);

    logic               grant_id_s;
    logic               accept_s;
    logic [31:0]        sel_addr_s;
    logic [31:0]        sel_off_s;
    logic [W-1:0]       sel_wdata_s;
    logic [COL_NUM-1:0] sel_wmask_s;
    logic               sel_in_range_s;

    logic last_q,       last_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_id_q,    resp_id_d;
    logic resp_err_q,   resp_err_d;

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        grant_id_s = 1'b0;
        if (m0_valid && m1_valid) begin
            grant_id_s = ~last_q;
        end else if (m1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        accept_s = !reset && (m0_valid || m1_valid);
    end

    // Select the winner's request; with no winner the m0 inputs pass through.
    always_comb begin
        sel_addr_s  = m0_addr;
        sel_wdata_s = m0_wdata;
        sel_wmask_s = m0_wmask;
        if (grant_id_s) begin
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wmask_s = m1_wmask;
        end else begin
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wmask_s = m0_wmask;
        end
        sel_off_s      = sel_addr_s - BASE_ADDR;
        sel_in_range_s = ({1'b0, sel_off_s} < SPAN);
    end

    // RAM port drive and handshake; out-of-range requests are accepted but never touch the RAM.
    always_comb begin
        ram_addr = sel_off_s[CB +: AW];
        ram_din  = sel_wdata_s;
        ram_en   = 1'b0;
        ram_we   = '0;
        if (accept_s && sel_in_range_s) begin
            ram_en = 1'b1;
            ram_we = sel_wmask_s;
        end else begin
            ram_en = 1'b0;
            ram_we = '0;
        end
        m0_ready = accept_s && !grant_id_s;
        m1_ready = accept_s && grant_id_s;
    end

    // Next state of the response stage and the round-robin pointer.
    always_comb begin
        resp_valid_d = 1'b0;
        resp_id_d    = 1'b0;
        resp_err_d   = 1'b0;
        last_d       = last_q;
        if (accept_s) begin
            resp_valid_d = 1'b1;
            resp_id_d    = grant_id_s;
            resp_err_d   = !sel_in_range_s;
            last_d       = grant_id_s;
        end else begin
            resp_valid_d = 1'b0;
            resp_id_d    = 1'b0;
            resp_err_d   = 1'b0;
            last_d       = last_q;
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Route the RAM's registered read data to the requester that owns the response.
    always_comb begin
        m0_rvalid = resp_valid_q && !resp_id_q;
        m1_rvalid = resp_valid_q && resp_id_q;
        m0_error  = m0_rvalid && resp_err_q;
        m1_error  = m1_rvalid && resp_err_q;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (m0_rvalid && !resp_err_q) begin
            m0_rdata = ram_dout;
        end else begin
            m0_rdata = '0;
        end
        if (m1_rvalid && !resp_err_q) begin
            m1_rdata = ram_dout;
        end else begin
            m1_rdata = '0;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// scored against a request-level model of the RAM contents and round-robin order.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_valid, m1_valid, b_valid;

    logic        a_m0_ready, a_m1_ready, a_m0_rvalid, a_m1_rvalid, a_m0_error, a_m1_error;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_ram_din, a_ram_dout;
    logic [13:0] a_ram_addr;
    logic        a_ram_en;
    logic [3:0]  a_ram_we;

    logic        b_m0_ready, b_m1_ready, b_m0_rvalid, b_m1_rvalid, b_m0_error, b_m1_error;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_din, b_ram_dout;
    logic [13:0] b_ram_addr;
    logic        b_ram_en;
    logic [3:0]  b_ram_we;

    logic        pl_en_a, pl_en_b;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;

    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:16383];
    logic [31:0] ref_a [0:16383];

    int n_cmp  = 0;
    int n_fail = 0;

    ram_port_arbiter u_dut_a (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_valid(m0_valid),
        .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid), .m0_error(a_m0_error),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_valid(m1_valid),
        .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid), .m1_error(a_m1_error),
        .ram_addr(a_ram_addr), .ram_din(a_ram_din), .ram_en(a_ram_en), .ram_we(a_ram_we),
        .ram_dout(a_ram_dout)
    );

    ram_port_arbiter #(.BASE_ADDR(32'h8000_0000)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_valid(b_valid),
        .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid), .m0_error(b_m0_error),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_valid(1'b0),
        .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid), .m1_error(b_m1_error),
        .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_dout(b_ram_dout)
    );

    // Column-masked write merge of the byte-column RAM.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] din, input logic [3:0] we);
        logic [31:0] r;
        r = old_w;
        for (int c = 0; c < 4; c++) begin
            if (we[c]) r[c*8 +: 8] = din[c*8 +: 8];
        end
        return r;
    endfunction

    // Write-first RAM models with a bench-side preload path.
    always @(posedge clk) begin
        if (pl_en_a) mem_a[pl_addr] <= pl_data;
        else if (a_ram_en) begin
            mem_a[a_ram_addr] <= merge(mem_a[a_ram_addr], a_ram_din, a_ram_we);
            a_ram_dout        <= merge(mem_a[a_ram_addr], a_ram_din, a_ram_we);
        end
        if (pl_en_b) mem_b[pl_addr] <= pl_data;
        else if (b_ram_en) begin
            mem_b[b_ram_addr] <= merge(mem_b[b_ram_addr], b_ram_din, b_ram_we);
            b_ram_dout        <= merge(mem_b[b_ram_addr], b_ram_din, b_ram_we);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_valid = 1'b0; m1_valid = 1'b0; b_valid = 1'b0;
        m0_wmask = 4'h0; m1_wmask = 4'h0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    endtask

    task automatic drv0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wmask = m;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wmask = m;
    endtask

    task automatic preload(input bit sel_b, input logic [13:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d;
        if (sel_b) pl_en_b = 1'b1; else pl_en_a = 1'b1;
        tick();
        pl_en_a = 1'b0; pl_en_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drv0(32'h10, 32'h1, 4'hF);
        drv1(32'h20, 32'h2, 4'hF);
        #1;
        n_cmp++; if (a_m0_ready !== 1'b0 || a_m1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b%b want 00", a_m0_ready, a_m1_ready); end
        n_cmp++; if (a_ram_en !== 1'b0 || a_ram_we !== 4'h0) begin n_fail++; $display("FAIL rst_ram got en=%b we=%h want 0/0", a_ram_en, a_ram_we); end
        tick(); tick();
        n_cmp++; if ({a_m0_rvalid, a_m1_rvalid, a_m0_error, a_m1_error} !== 4'b0000) begin n_fail++; $display("FAIL rst_resp got %b%b%b%b want 0000", a_m0_rvalid, a_m1_rvalid, a_m0_error, a_m1_error); end
        n_cmp++; if (a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h %h want 0", a_m0_rdata, a_m1_rdata); end
        idle();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read_basic();
        preload(1'b0, 14'd4, 32'hDEAD_BEEF);
        drv0(32'h10, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_m0_ready !== 1'b1 || a_m1_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready got %b%b want 10", a_m0_ready, a_m1_ready); end
        n_cmp++; if (a_ram_en !== 1'b1 || a_ram_addr !== 14'd4 || a_ram_we !== 4'h0) begin n_fail++; $display("FAIL basic_ram got en=%b addr=%0d we=%h want 1/4/0", a_ram_en, a_ram_addr, a_ram_we); end
        tick();
        idle();
        n_cmp++; if (a_m0_rvalid !== 1'b1 || a_m1_rvalid !== 1'b0 || a_m0_error !== 1'b0) begin n_fail++; $display("FAIL basic_rvalid got %b%b err %b want 10 err 0", a_m0_rvalid, a_m1_rvalid, a_m0_error); end
        n_cmp++; if (a_m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_rdata got %h want deadbeef", a_m0_rdata); end
        tick();
        n_cmp++; if (a_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL basic_strobe got %b want 0", a_m0_rvalid); end
    endtask

    task automatic test_write_read();
        preload(1'b0, 14'd8, 32'hAABB_CCDD);
        drv1(32'h20, 32'h1122_3344, 4'b0011);
        #1;
        n_cmp++; if (a_m1_ready !== 1'b1 || a_m0_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready got %b%b want 01", a_m0_ready, a_m1_ready); end
        n_cmp++; if (a_ram_en !== 1'b1 || a_ram_we !== 4'b0011 || a_ram_addr !== 14'd8 || a_ram_din !== 32'h1122_3344) begin n_fail++; $display("FAIL wr_ram got en=%b we=%b addr=%0d din=%h", a_ram_en, a_ram_we, a_ram_addr, a_ram_din); end
        tick();
        n_cmp++; if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 32'hAABB_3344) begin n_fail++; $display("FAIL wr_resp got %b %h want 1 aabb3344", a_m1_rvalid, a_m1_rdata); end
        drv1(32'h20, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_ram_en !== 1'b1 || a_ram_we !== 4'h0) begin n_fail++; $display("FAIL rd_ram got en=%b we=%h want 1/0", a_ram_en, a_ram_we); end
        tick();
        idle();
        n_cmp++; if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 32'hAABB_3344 || a_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_after_wr got %b %h want 1 aabb3344", a_m1_rvalid, a_m1_rdata); end
        tick();
    endtask

    // Both requesters valid every cycle; m1 was served last, so m0 wins first.
    task automatic test_tie_alternate();
        logic [31:0] w [0:3];
        int last_m = 1;
        int win;
        logic [31:0] a0, a1, exp_d;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            preload(1'b0, 14'(16 + i), w[i]);
        end
        for (int i = 0; i < 6; i++) begin
            a0 = 32'(64 + 4 * $urandom_range(0, 3));
            a1 = 32'(64 + 4 * $urandom_range(0, 3));
            drv0(a0, 32'h0, 4'h0);
            drv1(a1, 32'h0, 4'h0);
            win = 1 - last_m;
            exp_d = (win == 0) ? w[(a0 - 32'd64) >> 2] : w[(a1 - 32'd64) >> 2];
            #1;
            n_cmp++; if (a_m0_ready !== (win == 0) || a_m1_ready !== (win == 1)) begin n_fail++; $display("FAIL tie_grant[%0d] got %b%b want winner %0d", i, a_m0_ready, a_m1_ready, win); end
            tick();
            n_cmp++; if (a_m0_rvalid !== (win == 0) || a_m1_rvalid !== (win == 1)) begin n_fail++; $display("FAIL tie_rvalid[%0d] got %b%b want winner %0d", i, a_m0_rvalid, a_m1_rvalid, win); end
            n_cmp++; if (((win == 0) ? a_m0_rdata : a_m1_rdata) !== exp_d) begin n_fail++; $display("FAIL tie_rdata[%0d] got %h/%h want %h", i, a_m0_rdata, a_m1_rdata, exp_d); end
            last_m = win;
        end
        idle();
        tick();
    endtask

    task automatic test_out_of_range();
        preload(1'b0, 14'd16383, 32'h5A5A_A5A5);
        drv0(32'h0000_FFFC, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_ram_en !== 1'b1 || a_ram_addr !== 14'd16383) begin n_fail++; $display("FAIL top_ram got en=%b addr=%0d want 1/16383", a_ram_en, a_ram_addr); end
        tick();
        n_cmp++; if (a_m0_rdata !== 32'h5A5A_A5A5 || a_m0_error !== 1'b0) begin n_fail++; $display("FAIL top_rdata got %h err %b want 5a5aa5a5 err 0", a_m0_rdata, a_m0_error); end
        drv0(32'h0001_0000, 32'h1234_5678, 4'hF);
        #1;
        n_cmp++; if (a_m0_ready !== 1'b1 || a_ram_en !== 1'b0 || a_ram_we !== 4'h0) begin n_fail++; $display("FAIL oor_req got rdy=%b en=%b we=%h want 1/0/0", a_m0_ready, a_ram_en, a_ram_we); end
        tick();
        n_cmp++; if (a_m0_rvalid !== 1'b1 || a_m0_error !== 1'b1 || a_m0_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_resp got rv=%b err=%b d=%h want 1/1/0", a_m0_rvalid, a_m0_error, a_m0_rdata); end
        drv0(32'h0, 32'h0, 4'h0);
        drv1(32'h0, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_m1_ready !== 1'b1 || a_m0_ready !== 1'b0) begin n_fail++; $display("FAIL oor_last got %b%b want 01", a_m0_ready, a_m1_ready); end
        tick();
        idle();
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h0001_0000 + 32'($urandom_range(0, 255));
        if (r < 8) return 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
        return 32'(4 * $urandom_range(16380, 16383) + $urandom_range(0, 3));
    endfunction

    // Random traffic; the previous grant went to m1.
    task automatic test_random();
        int last_m = 1;
        int win;
        bit v0, v1, acc, inr;
        logic [31:0] a, d, off, exp_d;
        logic [3:0] m;
        logic [13:0] wd;
        for (int i = 0; i < 20; i++) begin
            wd = (i < 16) ? 14'(i) : 14'(16380 + i - 16);
            ref_a[wd] = $urandom;
            preload(1'b0, wd, ref_a[wd]);
        end
        for (int i = 0; i < 300; i++) begin
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 7);
            m0_valid = v0; m0_addr = rand_addr(); m0_wdata = $urandom; m0_wmask = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            m1_valid = v1; m1_addr = rand_addr(); m1_wdata = $urandom; m1_wmask = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            acc = v0 || v1;
            win = (v0 && v1) ? (1 - last_m) : (v1 ? 1 : 0);
            a = (win == 1) ? m1_addr : m0_addr;
            d = (win == 1) ? m1_wdata : m0_wdata;
            m = (win == 1) ? m1_wmask : m0_wmask;
            off = a;
            inr = (off < 32'd65536);
            wd = 14'(off >> 2);
            exp_d = 32'h0;
            if (acc && inr) begin
                ref_a[wd] = merge(ref_a[wd], d, m);
                exp_d = ref_a[wd];
            end
            if (acc) last_m = win;
            #1;
            n_cmp++; if (a_m0_ready !== (acc && win == 0) || a_m1_ready !== (acc && win == 1)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b%b want acc=%b win=%0d", i, a_m0_ready, a_m1_ready, acc, win); end
            n_cmp++; if (a_ram_en !== (acc && inr) || a_ram_we !== ((acc && inr) ? m : 4'h0)) begin n_fail++; $display("FAIL rnd_ram[%0d] got en=%b we=%h want %b/%h", i, a_ram_en, a_ram_we, acc && inr, (acc && inr) ? m : 4'h0); end
            if (acc && inr) begin
                n_cmp++; if (a_ram_addr !== wd) begin n_fail++; $display("FAIL rnd_addr[%0d] got %0d want %0d", i, a_ram_addr, wd); end
            end
            tick();
            n_cmp++; if (a_m0_rvalid !== (acc && win == 0) || a_m1_rvalid !== (acc && win == 1)) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got %b%b", i, a_m0_rvalid, a_m1_rvalid); end
            n_cmp++; if (a_m0_error !== (acc && win == 0 && !inr) || a_m1_error !== (acc && win == 1 && !inr)) begin n_fail++; $display("FAIL rnd_error[%0d] got %b%b inr=%b", i, a_m0_error, a_m1_error, inr); end
            n_cmp++; if (a_m0_rdata !== ((win == 0) ? exp_d : 32'h0) || a_m1_rdata !== ((win == 1) ? exp_d : 32'h0)) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h/%h want %h to m%0d", i, a_m0_rdata, a_m1_rdata, exp_d, win); end
        end
        idle();
        tick();
    endtask

    task automatic test_base_hi();
        preload(1'b1, 14'd1, 32'hCAFE_F00D);
        b_valid = 1'b1; m0_addr = 32'h7FFF_FFFC; m0_wmask = 4'h0;
        #1;
        n_cmp++; if (b_m0_ready !== 1'b1 || b_ram_en !== 1'b0) begin n_fail++; $display("FAIL base_below got rdy=%b en=%b want 1/0", b_m0_ready, b_ram_en); end
        tick();
        n_cmp++; if (b_m0_rvalid !== 1'b1 || b_m0_error !== 1'b1 || b_m0_rdata !== 32'h0) begin n_fail++; $display("FAIL base_below_resp got %b %b %h want 1 1 0", b_m0_rvalid, b_m0_error, b_m0_rdata); end
        m0_addr = 32'h8000_0004;
        #1;
        n_cmp++; if (b_ram_en !== 1'b1 || b_ram_addr !== 14'd1) begin n_fail++; $display("FAIL base_in got en=%b addr=%0d want 1/1", b_ram_en, b_ram_addr); end
        tick();
        idle();
        n_cmp++; if (b_m0_rvalid !== 1'b1 || b_m0_error !== 1'b0 || b_m0_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL base_in_resp got %b %b %h want 1 0 cafef00d", b_m0_rvalid, b_m0_error, b_m0_rdata); end
        n_cmp++; if ({b_m1_ready, b_m1_rvalid, b_m1_error} !== 3'b000 || b_m1_rdata !== 32'h0) begin n_fail++; $display("FAIL base_m1_idle got %b%b%b %h", b_m1_ready, b_m1_rvalid, b_m1_error, b_m1_rdata); end
        tick();
    endtask

    task automatic test_reset_pending();
        drv0(32'h10, 32'h0, 4'h0);
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (a_m0_rvalid !== 1'b0 || a_ram_en !== 1'b0 || a_m0_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_during got rv=%b en=%b rdy=%b want 0/0/0", a_m0_rvalid, a_ram_en, a_m0_ready); end
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        n_cmp++; if (a_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstp_release got %b want 0", a_m0_rvalid); end
        tick();
        n_cmp++; if (a_m0_rvalid !== 1'b0 || a_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstp_after got %b%b want 00", a_m0_rvalid, a_m1_rvalid); end
    endtask

    initial begin
        pl_en_a = 1'b0; pl_en_b = 1'b0; pl_addr = 14'd0; pl_data = 32'h0;
        reset = 1'b1;
        idle();
        test_reset();
        test_read_basic();
        test_write_read();
        test_tie_alternate();
        test_out_of_range();
        test_random();
        test_base_hi();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares one port of the team's dual-port, byte-column-write block RAM between two bus requesters (e.g. data-memory unit and debug/DMA master). It decodes byte addresses into RAM word addresses, arbitrates round-robin on a valid/ready handshake, drives the RAM port's enable, write-enable and data lines, and routes the RAM's 1-cycle registered read data back to the winning requester with a response-valid strobe and an out-of-range error flag.

## Interface
- RAM_DEPTH, 16384: words in the attached RAM.
- COL_WIDTH, 8: bits per byte-enable column.
- COL_NUM, 4: columns per word; data width W = COL_NUM*COL_WIDTH.
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_addr / m1_addr  in  32  byte address of request.
- m0_wdata / m1_wdata  in  W  write data.
- m0_wmask / m1_wmask  in  COL_NUM  column write mask; all-zero = read.
- m0_valid / m1_valid  in  1  request valid.
- m0_ready / m1_ready  out  1  request accepted this cycle (combinational grant).
- m0_rdata / m1_rdata  out  W  response data.
- m0_rvalid / m1_rvalid  out  1  one-cycle response strobe.
- m0_error / m1_error  out  1  response is out-of-range error; valid with rvalid.
- ram_addr  out  $clog2(RAM_DEPTH)  RAM word address.
- ram_din  out  W  RAM write data.
- ram_en  out  1  RAM port enable.
- ram_we  out  COL_NUM  RAM column write enables.
- ram_dout  in  W  RAM registered read data (valid one cycle after ram_en).

## Operation
- Decode: offset = addr - BASE_ADDR (32-bit, wrapping); in range iff offset < RAM_DEPTH*COL_NUM; word address = offset >> $clog2(COL_NUM); low offset bits ignored (no misalignment check).
- Arbitration: only m0 valid -> grant m0; only m1 valid -> grant m1; both -> grant requester not granted last (pointer `last`, reset value m0 = last so m1 wins first tie? No: reset `last`=1, so m0 wins the first tie).
- `last` updates on every accepted request (in or out of range), to the granted index.
- Exactly one request accepted per cycle; mX_ready = grant to X; ready low when own valid low.
- Accepted in-range: ram_en=1, ram_addr=word address, ram_din=wdata, ram_we=wmask. Accepted out-of-range: ram_en=0, ram_we=0.
- No accept: ram_en=0, ram_we=0; ram_addr/ram_din don't-care (drive from m0 inputs).
- Response stage registers: resp_valid, resp_id, resp_err. Set on accept, cleared otherwise.
- Response cycle: mX_rvalid = resp_valid && resp_id==X; mX_rdata = ram_dout if rvalid and !resp_err, else 0; mX_error = rvalid && resp_err.
- Writes also get a response; rdata = ram_dout (written columns show new data, others old word contents, per RAM write-first behaviour).
- Responses cannot be back-pressured; requester must take rvalid in its cycle.

## Timing
- Request accept cycle N -> RAM access edge end of N -> rvalid in cycle N+1. Latency 1, throughput 1 request/cycle.
- Back-to-back accepts to alternating requesters produce rvalid alternately on consecutive cycles, no bubble.
- Reset values: rvalid 0, error 0, rdata 0 for both; `last`=1; resp_valid 0. ram_en and ram_we are 0 while reset is high regardless of inputs; ready 0 while reset high.
- Reset asserted with response pending: response discarded, no rvalid after reset release.
- Same-address write then read on consecutive cycles: read returns newly written columns.

## Test plan
- Reset then m0 read addr 0x10 (BASE 0), RAM word 4 = 0xDEADBEEF -> cycle N: m0_ready=1, ram_en=1, ram_addr=4, ram_we=0; N+1: m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- m1 write addr 0x20, wdata 0x11223344, wmask 4'b0011, then m1 read 0x20, word held 0xAABBCCDD -> ram_we=0011 first cycle; read response 0xAABB3344.
- m0 and m1 valid continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1; rvalid alternates accordingly, no idle cycles.
- m0 read addr = RAM_DEPTH*4 (0x10000) -> m0_ready=1, ram_en=0; next cycle m0_rvalid=1, m0_error=1, m0_rdata=0; `last` updated so a following tie grants m1.
- BASE_ADDR=0x8000_0000, m0 read 0x7FFF_FFFC -> error response; 0x8000_0004 -> ram_addr=1, no error.
- Accept m0 read, assert reset in cycle N+1 before edge -> m0_rvalid=0 during and after reset, ram_en=0 during reset.
